jtframe_romarb: RTL and testbench
=================================

# jtframe_romarb

Parametrised SDRAM read arbiter serving CH independent ROM-fetch channels over one shared 32-bit SDRAM read port. It sits between the game's per-subsystem ROM requesters (CPU, object, character, sound, ...) and the SDRAM controller, and succeeds the fixed two-channel ROM muxes. Channels supply ready-made word addresses, including any region offset. Arbitration is round-robin or fixed priority. A data timeout re-issues any request the controller drops.

## Interface
Parameters:
- CH, 4: number of channels (2..8).
- PRIO, 0: 0 = round-robin, 1 = fixed priority (highest index wins).
- READY_DLY, 16: cycles from reset/download end to `ready`.
- TOUT, 255: WAIT_DATA cycles before the request is re-issued (8-bit, ≥2).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- downloading  in  1  ROM download active; acts as synchronous clear.
- loop_rst  in  1  controller loop reset; acts as synchronous clear.
- ch_req  in  CH  per-channel level request; held until its ch_ok.
- ch_addr  in  22*CH  channel i word address at [22i+21:22i].
- ch_ok  out  CH  one-cycle pulse: ch_data valid for that channel.
- ch_data  out  32  last returned word; held until the next completion.
- ready  out  1  high once READY_DLY cycles have elapsed since clear.
- sdram_req  out  1  read request to controller.
- sdram_addr  out  22  word address of current request.
- sdram_ack  in  1  controller accepted request.
- data_rdy  in  1  data_read valid.
- data_read  in  32  SDRAM read data.
- refresh_en  out  1  controller may refresh.

## Operation
- Clear (rst_n low, downloading or loop_rst high):
  - State → IDLE; sdram_req, ch_ok and ready → 0.
  - sdram_addr and ch_data → 0; refresh_en → 1.
  - Timeout and ready counters → 0; last_grant → CH-1.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
- IDLE:
  - valid = ch_req & ~mask. mask is the last-granted bit, only in the cycle its ch_ok is high; it stops re-grant before the requester drops ch_req.
  - If valid≠0, pick a winner. PRIO=0: first set bit searching upward from last_grant+1, wrapping at CH-1→0. PRIO=1: highest set index.
  - On a grant: latch sdram_addr from the winner's ch_addr, set grant and last_grant, sdram_req←1, → WAIT_ACK.
- WAIT_ACK:
  - sdram_ack: sdram_req←0, timer←0, → WAIT_DATA.
  - sdram_ack with data_rdy in the same cycle: complete immediately (as WAIT_DATA).
  - data_rdy without ack: ignored.
- WAIT_DATA:
  - data_rdy: ch_data←data_read, ch_ok[grant]←1 for one cycle, → IDLE.
  - Otherwise timer increments. At timer==TOUT-1, sdram_req←1 with the same address, → WAIT_ACK (retry). The grant is kept.
- Request withdrawal: dropping ch_req mid-transaction does not abort it. Data is still delivered with ch_ok.
- ch_addr changes after the grant are ignored until the next grant.
- refresh_en = 1 only in IDLE when valid==0. It is registered, so it follows state one cycle late.
- ready: counter saturates at READY_DLY; ready←1 when it is reached.

## Timing
- Grant: ch_req seen in IDLE at edge N → sdram_req and sdram_addr valid after edge N.
- sdram_ack at edge M → sdram_req low after edge M.
- data_rdy at edge K → ch_ok and ch_data valid after edge K; state is IDLE after edge K.
- Earliest next grant is edge K+1, so there is one turnaround cycle per transaction.
- Minimum transaction: 3 cycles if ack and data arrive on successive cycles.
- A channel holding ch_req continuously is re-served at the earliest in the cycle after its ch_ok deasserts. Under round-robin every other pending channel is served first.
- Clear mid-transaction: takes effect next edge. No ch_ok is issued. A late data_rdy arriving in IDLE is ignored.

## Test plan
- Clear: assert rst_n=0 → all outputs at clear values. Release rst_n → ready rises exactly 16 cycles later.
- Single request: ch_req=4'b0010, ch_addr[1]=22'h01234; ack at +2, data_rdy at +5 with 32'hDEADBEEF.
  - Required: sdram_addr=22'h01234 with sdram_req low after ack.
  - Required: ch_ok=4'b0010 for one cycle with ch_data=32'hDEADBEEF; no re-grant in that cycle.
- Round-robin: ch_req=4'b1111 held and re-asserted after each ok → grant order 0,1,2,3,0. With PRIO=1 → 3 every time.
- Timeout: ack given, data_rdy withheld → after TOUT cycles sdram_req re-asserts with the same address. Data on the retry → single ch_ok.
- Clear in WAIT_DATA: loop_rst pulse, then stray data_rdy → no ch_ok, state IDLE, refresh_en=1.
- Ack and data in the same cycle → completes, ch_ok next cycle, sdram_req low.

Source files
------------

// File: rtl/jtframe_romarb.sv
// rtl/jtframe_romarb.sv - multi-channel SDRAM ROM read arbiter with retry timeout
// Serves CH ROM-fetch channels over one SDRAM read port, round-robin or fixed priority.
module jtframe_romarb #(
  parameter int CH        = 4,
  parameter int PRIO      = 0,
  parameter int READY_DLY = 16,
  parameter int TOUT      = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             downloading,
  input  logic             loop_rst,
  input  logic [CH-1:0]    ch_req,
  input  logic [22*CH-1:0] ch_addr,
  output logic [CH-1:0]    ch_ok,
  output logic [31:0]      ch_data,
  output logic             ready,
  output logic             sdram_req,
  output logic [21:0]      sdram_addr,
  input  logic             sdram_ack,
  input  logic             data_rdy,
  input  logic [31:0]      data_read,
  output logic             refresh_en
);

  localparam int GW = $clog2(CH);
  localparam int RW = $clog2(READY_DLY + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t          state_q;
  logic [GW-1:0]   last_q;
  logic [CH-1:0]   ch_ok_q;
  logic [31:0]     ch_data_q;
  logic [21:0]     addr_q;
  logic            req_q;
  logic            ready_q;
  logic            refresh_q;
  logic [7:0]      timer_q;
  logic [RW-1:0]   rdy_cnt_q;

  logic [CH-1:0]   valid;
  logic [GW-1:0]   win;
  logic [GW-1:0]   idx;
  logic            found;
  int unsigned     idx_i;

  // The channel just completed is masked while its ch_ok is high, so a
  // requester that drops ch_req on ch_ok is never granted twice.
  always_comb begin
    valid = ch_req & ~ch_ok_q;
    win   = '0;
    idx   = '0;
    idx_i = 0;
    found = 1'b0;
    if (PRIO != 0) begin
      for (int i = 0; i < CH; i++) begin
        if (valid[i]) begin
          win   = GW'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        idx_i = (int'(last_q) + k) % CH;
        idx   = idx_i[GW-1:0];
        if (!found && valid[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || downloading || loop_rst) begin
      state_q   <= IDLE;
      last_q    <= GW'(CH - 1);
      ch_ok_q   <= '0;
      ch_data_q <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      ready_q   <= 1'b0;
      refresh_q <= 1'b1;
      timer_q   <= '0;
      rdy_cnt_q <= '0;
    end else begin
      ch_ok_q   <= '0;
      refresh_q <= (state_q == IDLE) && !found;
      if (rdy_cnt_q != RW'(READY_DLY)) rdy_cnt_q <= rdy_cnt_q + 1'b1;
      ready_q <= (rdy_cnt_q >= RW'(READY_DLY - 1));
      case (state_q)
        IDLE: begin
          if (found) begin
            addr_q  <= ch_addr[22*int'(win) +: 22];
            last_q  <= win;
            req_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_q   <= 1'b0;
            timer_q <= '0;
            if (data_rdy) begin
              ch_data_q       <= data_read;
              ch_ok_q[last_q] <= 1'b1;
              state_q         <= IDLE;
            end else begin
              state_q <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (data_rdy) begin
            ch_data_q       <= data_read;
            ch_ok_q[last_q] <= 1'b1;
            state_q         <= IDLE;
          end else if (timer_q == 8'(TOUT - 1)) begin
            req_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_ok      = ch_ok_q;
  assign ch_data    = ch_data_q;
  assign ready      = ready_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jtframe_romarb.sv
// tb/tb_jtframe_romarb.sv - directed self-checking bench for jtframe_romarb
// Drives a round-robin and a fixed-priority instance from the same stimulus.
module tb_jtframe_romarb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        loop_rst = 1'b0;
  logic [3:0]  ch_req = '0;
  logic [87:0] ch_addr = '0;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] data_read = '0;

  logic [3:0]  ch_ok, ch_ok_p;
  logic [31:0] ch_data, ch_data_p;
  logic        ready, ready_p, sdram_req, sdram_req_p, refresh_en, refresh_en_p;
  logic [21:0] sdram_addr, sdram_addr_p;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jtframe_romarb #(.CH(4), .PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_ok(ch_ok), .ch_data(ch_data),
    .ready(ready), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en)
  );

  jtframe_romarb #(.CH(4), .PRIO(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_ok(ch_ok_p), .ch_data(ch_data_p),
    .ready(ready_p), .sdram_req(sdram_req_p), .sdram_addr(sdram_addr_p),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ch_req = 4'b0101;
    tick(); tick();
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", sdram_req); end
    total++; if (ch_ok !== 4'b0) begin bad++; $display("FAIL reset_ok got=%b exp=0000", ch_ok); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", ready); end
    total++; if (sdram_addr !== 22'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", sdram_addr); end
    total++; if (ch_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", ch_data); end
    total++; if (refresh_en !== 1'b1) begin bad++; $display("FAIL reset_refresh got=%0b exp=1", refresh_en); end
    ch_req = 4'b0000;
    rst_n = 1'b1;
    repeat (15) tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_early got=%0b exp=0", ready); end
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_16 got=%0b exp=1", ready); end
  endtask

  task automatic test_single();
    ch_addr[22*1 +: 22] = 22'h01234;
    ch_addr[22*0 +: 22] = 22'h3FFFF;
    ch_req = 4'b0010;
    tick();
    total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL single_req got=%0b exp=1", sdram_req); end
    total++; if (sdram_addr !== 22'h01234) begin bad++; $display("FAIL single_addr got=%h exp=01234", sdram_addr); end
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL single_req_after_ack got=%0b exp=0", sdram_req); end
    total++; if (sdram_addr !== 22'h01234) begin bad++; $display("FAIL single_addr_hold got=%h exp=01234", sdram_addr); end
    tick(); tick();
    data_read = 32'hDEADBEEF; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    total++; if (ch_ok !== 4'b0010) begin bad++; $display("FAIL single_ok got=%b exp=0010", ch_ok); end
    total++; if (ch_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", ch_data); end
    tick();
    total++; if (ch_ok !== 4'b0000) begin bad++; $display("FAIL single_ok_pulse got=%b exp=0000", ch_ok); end
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL single_no_regrant got=%0b exp=0", sdram_req); end
    ch_req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    ch_addr[22*2 +: 22] = 22'h2ABCD;
    ch_req = 4'b0100;
    tick();
    total++; if (sdram_addr !== 22'h2ABCD) begin bad++; $display("FAIL tout_addr got=%h exp=2abcd", sdram_addr); end
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    ch_req = 4'b0000;
    ch_addr[22*2 +: 22] = 22'h00155;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL tout_req_low got=%0b exp=0", sdram_req); end
    repeat (254) tick();
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL tout_early got=%0b exp=0", sdram_req); end
    tick();
    total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL tout_retry got=%0b exp=1", sdram_req); end
    total++; if (sdram_addr !== 22'h2ABCD) begin bad++; $display("FAIL tout_retry_addr got=%h exp=2abcd", sdram_addr); end
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    tick();
    data_read = 32'h0BADF00D; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    total++; if (ch_ok !== 4'b0100) begin bad++; $display("FAIL tout_ok got=%b exp=0100", ch_ok); end
    total++; if (ch_data !== 32'h0BADF00D) begin bad++; $display("FAIL tout_data got=%h exp=0badf00d", ch_data); end
    tick();
    total++; if (ch_ok !== 4'b0000) begin bad++; $display("FAIL tout_single_ok got=%b exp=0000", ch_ok); end
  endtask

  task automatic test_clear_wait_data();
    ch_addr[22*0 +: 22] = 22'h00100;
    ch_req = 4'b0001;
    tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    ch_req = 4'b0000;
    loop_rst = 1'b1; tick(); loop_rst = 1'b0;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL clr_req got=%0b exp=0", sdram_req); end
    total++; if (refresh_en !== 1'b1) begin bad++; $display("FAIL clr_refresh got=%0b exp=1", refresh_en); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%0b exp=0", ready); end
    total++; if (sdram_addr !== 22'h0) begin bad++; $display("FAIL clr_addr got=%h exp=0", sdram_addr); end
    data_read = 32'hCAFEF00D; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    total++; if (ch_ok !== 4'b0000) begin bad++; $display("FAIL clr_stray_ok got=%b exp=0000", ch_ok); end
    total++; if (ch_data !== 32'h0) begin bad++; $display("FAIL clr_data got=%h exp=0", ch_data); end
    tick();
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL clr_idle_req got=%0b exp=0", sdram_req); end
    total++; if (refresh_en !== 1'b1) begin bad++; $display("FAIL clr_idle_refresh got=%0b exp=1", refresh_en); end
  endtask

  task automatic test_round_robin();
    logic [21:0] exp_addr;
    int n;
    for (int i = 0; i < 4; i++) ch_addr[22*i +: 22] = 22'h00100 + 22'(i);
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin tick(); n++; end while (!sdram_req && n < 8);
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL rr_grant_%0d got=%0b exp=1", k, sdram_req); end
      exp_addr = 22'h00100 + 22'(k % 4);
      total++; if (sdram_addr !== exp_addr) begin bad++; $display("FAIL rr_order_%0d got=%h exp=%h", k, sdram_addr, exp_addr); end
      total++; if (sdram_addr_p !== 22'h00103) begin bad++; $display("FAIL prio_order_%0d got=%h exp=00103", k, sdram_addr_p); end
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
      data_read = 32'hA0000000 + 32'(k); data_rdy = 1'b1; tick(); data_rdy = 1'b0;
      total++; if (ch_ok !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_ok_%0d got=%b exp=%b", k, ch_ok, 4'(1 << (k % 4))); end
      total++; if (ch_ok_p !== 4'b1000) begin bad++; $display("FAIL prio_ok_%0d got=%b exp=1000", k, ch_ok_p); end
      ch_req = 4'b0000;
      tick();
      ch_req = 4'b1111;
    end
    ch_req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_ack_data_same_cycle();
    ch_addr[22*3 +: 22] = 22'h3C0DE;
    ch_req = 4'b1000;
    tick();
    total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL same_req got=%0b exp=1", sdram_req); end
    data_read = 32'h11111111; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    total++; if (ch_ok !== 4'b0000) begin bad++; $display("FAIL same_noack_ok got=%b exp=0000", ch_ok); end
    total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL same_noack_req got=%0b exp=1", sdram_req); end
    data_read = 32'h12345678; data_rdy = 1'b1; sdram_ack = 1'b1; tick();
    data_rdy = 1'b0; sdram_ack = 1'b0; ch_req = 4'b0000;
    total++; if (ch_ok !== 4'b1000) begin bad++; $display("FAIL same_ok got=%b exp=1000", ch_ok); end
    total++; if (ch_data !== 32'h12345678) begin bad++; $display("FAIL same_data got=%h exp=12345678", ch_data); end
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL same_req_low got=%0b exp=0", sdram_req); end
    tick();
    total++; if (ch_ok !== 4'b0000) begin bad++; $display("FAIL same_ok_pulse got=%b exp=0000", ch_ok); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_timeout();
    test_clear_wait_data();
    test_round_robin();
    test_ack_data_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
